// File: rtl/seq_ctrl_pkg.sv
// Shared types and default constants for the serial stream controller and its pattern matcher.
package seq_ctrl_pkg;

    localparam int WORD_W_DEF = 16;
    localparam int PAT_W_DEF  = 4;
    localparam int CNT_W_DEF  = 8;

    localparam logic [PAT_W_DEF-1:0] PAT_RST_DEF = 4'b1001;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_e;

endpackage

// File: rtl/pattern_match_fsm.sv
// Programmable Mealy bit-pattern matcher; history persists across words until reset or a config load.
module pattern_match_fsm
    import seq_ctrl_pkg::*;
#(
    parameter int               PAT_W   = PAT_W_DEF,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_RST_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             detect
);

    localparam int FILL_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  pat_q, pat_d;
    logic              ovl_q, ovl_d;
    logic [PAT_W-2:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0]  window;

    assign window = {hist_q, bit_in};
    assign detect = bit_valid && (fill_q == FILL_FULL) && (window == pat_q);

    always_comb begin
        pat_d  = pat_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        if (cfg_load) begin
            pat_d  = cfg_pattern;
            ovl_d  = cfg_overlap;
            hist_d = '0;
            fill_d = '0;
        end else if (bit_valid) begin
            hist_d = window[PAT_W-2:0];
            // Non-overlapping mode restarts the fill so the next match needs a full fresh pattern.
            if (detect && !ovl_q) begin
                fill_d = '0;
            end else if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q  <= PAT_RST;
            ovl_q  <= 1'b1;
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            pat_q  <= pat_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_stream_ctrl.sv
// Word serializer feeding a pattern matcher, reporting matches per word.
// Optional SEQ_CTRL_TOTAL_EN adds a saturating running total_count of detects.
//
//   state  | meaning
//   IDLE   | waiting for a word, config writes accepted
//   SHIFT  | presenting one bit per cycle, MSB first
//   REPORT | one-cycle out_valid with the word's match count
module seq_stream_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int               WORD_W  = WORD_W_DEF,
    parameter int               PAT_W   = PAT_W_DEF,
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_RST_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic              cfg_overlap,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              detect,
    output logic              out_valid,
    output logic [CNT_W-1:0]  out_count,
    output logic              busy
`ifdef SEQ_CTRL_TOTAL_EN
    ,
    output logic [15:0]       total_count
`endif
);

    localparam int IDX_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              bit_valid_q, bit_valid_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              accept;
    logic              cfg_load;

    assign accept   = in_valid && in_ready_q && (state_q == IDLE);
    assign cfg_load = cfg_we && (state_q == IDLE);

    assign in_ready  = in_ready_q;
    assign bit_valid = bit_valid_q;
    assign bit_out   = sr_q[WORD_W-1];
    assign out_valid = out_valid_q;
    assign out_count = cnt_q;
    assign busy      = busy_q;

    pattern_match_fsm #(
        .PAT_W   (PAT_W),
        .PAT_RST (PAT_RST)
    ) u_match (
        .clk         (clk),
        .rst         (rst),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_overlap (cfg_overlap),
        .bit_valid   (bit_valid_q),
        .bit_in      (sr_q[WORD_W-1]),
        .detect      (detect)
    );

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sr_d    = in_word;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = {sr_q[WORD_W-2:0], 1'b0};
                idx_d = idx_q + 1'b1;
                if (detect && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (idx_q == IDX_LAST) begin
                    state_d = REPORT;
                end
            end
            REPORT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs are decoded from the next state so they are registered alongside it.
        in_ready_d  = (state_d == IDLE);
        bit_valid_d = (state_d == SHIFT);
        out_valid_d = (state_d == REPORT);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            bit_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            bit_valid_q <= bit_valid_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

`ifdef SEQ_CTRL_TOTAL_EN
    logic [15:0] total_q, total_d;

    assign total_count = total_q;

    always_comb begin
        total_d = total_q;
        if (detect && (total_q != 16'hFFFF)) begin
            total_d = total_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end
`endif

endmodule

// File: doc/seq_stream_ctrl.md
Name: seq_stream_ctrl

Overview:
- Sequencing controller for the serial pattern-detector datapath.
- Accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, into an embedded programmable Mealy pattern matcher.
- Reports the number of matches found in each word.
- Pattern and overlap mode are runtime-configurable; match history persists across consecutive words so that patterns spanning a word boundary are detected.

Parameters:
- WORD_W, 16: input word width; bits serialized per transaction.
- PAT_W, 4: pattern length in bits (>=2, <=WORD_W).
- CNT_W, 8: per-word match counter width.
- PAT_RST, 4'b1001: pattern loaded at reset, width PAT_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low (rst=0 resets).
- cfg_we  in  1  config write strobe.
- cfg_pattern  in  PAT_W  pattern, MSB = first bit in time.
- cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping.
- in_valid  in  1  in_word valid.
- in_ready  out  1  controller can accept a word.
- in_word  in  WORD_W  word to serialize.
- bit_out  out  1  current serialized bit.
- bit_valid  out  1  bit_out is valid this cycle.
- detect  out  1  Mealy match flag for the current bit_out.
- out_valid  out  1  one-cycle pulse: out_count valid.
- out_count  out  CNT_W  matches in the completed word.
- busy  out  1  high in SHIFT or REPORT.

Behaviour:
- Reset (rst=0, async):
  - All outputs 0.
  - FSM goes to IDLE; match history cleared.
  - Pattern = PAT_RST; overlap = 1.
- FSM states: IDLE, SHIFT, REPORT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_word into the shift register, clear the word counter, go to SHIFT.
- SHIFT:
  - Lasts exactly WORD_W cycles. bit_valid=1; bit_out = register MSB; register shifts left each cycle.
  - The bit index counter runs 0..WORD_W-1. At index WORD_W-1, go to REPORT.
- REPORT:
  - One cycle. out_valid=1; out_count holds the registered match count.
  - Returns to IDLE; in_ready rises the following cycle.
- Latency:
  - Word accepted at edge 0; bits presented in cycles 1..WORD_W; out_valid in cycle WORD_W+1.
  - Throughput is one word per WORD_W+2 cycles.
- Matcher:
  - PAT_W-1 bit history register plus fill counter 0..PAT_W-1.
  - detect is combinational: bit_valid && fill==PAT_W-1 && {history,bit_out}==pattern.
  - History and fill update only when bit_valid=1.
  - After a match with overlap=0, fill is cleared to 0.
  - History and fill are NOT cleared between words, only by reset or a config write.
- Count:
  - The per-word counter clears on accept and increments on detect.
  - It saturates at 2^CNT_W-1 and does not wrap.
- Configuration:
  - cfg_we is honoured only in IDLE and ignored in SHIFT/REPORT.
  - A write loads the pattern and overlap mode and clears history and fill.
  - If cfg_we and accept occur in the same IDLE cycle, both take effect and the new config applies to that word.
- in_valid held high in REPORT is not accepted until IDLE. in_word is sampled only at accept.
- Reset asserted mid-SHIFT:
  - Transaction is abandoned; no out_valid.
  - Outputs go to 0 immediately.

Optional Feature:
- Macro: SEQ_CTRL_TOTAL_EN.
- When defined:
  - Adds output port total_count [15:0]: running total of detect pulses since reset.
  - Saturates at 16'hFFFF; not cleared by config writes.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package seq_ctrl_pkg holds:
  - state enum (IDLE=2'd0, SHIFT=2'd1, REPORT=2'd2);
  - default PAT_W, WORD_W and CNT_W constants;
  - the PAT_RST constant.
- One sub-module, pattern_match_fsm: holds history, fill and pattern registers; produces detect.
- The top level holds the handshake FSM, shift register, bit counter and match counters.

Test Plan:
- Pattern reset default 1001, overlap=1, word 16'h4952:
  - detect in cycles 5, 8 and 15 after accept;
  - out_valid in cycle 17 with out_count=3.
- Same word after cfg_overlap=0 (pattern 1001):
  - detect in cycles 5 and 15 only;
  - out_count=2.
- Boundary, overlap=1, pattern 1001, word 16'h0004 then 16'h8000 back-to-back:
  - word 1 out_count=0;
  - word 2 detect on its first bit, out_count=1.
- Saturation, CNT_W=2, pattern 4'b0000, overlap=1, word 16'h0000:
  - 13 detects;
  - out_count=3.
- cfg_we during SHIFT is ignored. Reset pulse at bit index 6:
  - no out_valid;
  - outputs 0;
  - next word uses pattern 1001 with empty history.
- With SEQ_CTRL_TOTAL_EN: the first and third scenarios run back-to-back give total_count=4.
